pio_in_edge_irq: RTL and testbench
==================================

# pio_in_edge_irq

Parametrised input-only PIO slave for the Nios II system bus: samples up to 32 external inputs through a synchroniser and an optional per-bit debouncer. It captures selected edges in a sticky register and raises a maskable interrupt. It replaces the fixed 1-bit, polled-only input PIO with one block that serves switches, push-buttons and status lines.

## Interface
Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..3).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value follows the input; 0 disables the debouncer (0..65535).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 1, 0 = level (irq from debounced data), 1 = edge (irq from edgecapture).

Ports:
- clk  in  1  system clock; the block has one clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select; qualifies write.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; bits 31:WIDTH always 0.
- irq  out  1  registered interrupt request, active high.

## Operation
- Register map, selected by address:
  - 0 data: read-only debounced value; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irqmask: read/write; bits WIDTH-1:0.
  - 3 edgecapture: read/write-1-to-clear.
- Synchroniser: SYNC_STAGES flops per bit. Output is sync.
- Debouncer, per bit, when DEBOUNCE_CYCLES > 0:
  - A counter of width clog2(DEBOUNCE_CYCLES+1) increments each cycle that sync differs from deb.
  - The counter clears to 0 on any cycle sync equals deb.
  - deb takes sync on the edge where the counter would reach DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
  - When DEBOUNCE_CYCLES = 0, deb is sync directly with no added register.
- Edge detect: deb_d is deb delayed one clock.
  - rise = deb & ~deb_d; fall = ~deb & deb_d.
  - EDGE_TYPE selects rise, fall or rise|fall.
- edgecapture bit sets on a detected edge and holds until cleared.
- Write (chipselect=1, write_n=0):
  - address 2: irqmask <= writedata[WIDTH-1:0].
  - address 3: clears the edgecapture bits where writedata is 1.
  - address 0 and 1: no effect.
- Same-cycle set and clear on one edgecapture bit: set wins.
- Readdata: updated every clock from the current address; no read strobe, no side effects.
- irq is registered each clock:
  - IRQ_MODE 0: irq <= |(deb & irqmask).
  - IRQ_MODE 1: irq <= |(edgecapture & irqmask).
- Reset (asynchronous, any time including mid-debounce): sync chain, counters, deb, deb_d, irqmask, edgecapture, readdata and irq all go to 0.
  - An input held high through reset produces one rising-edge capture after release.
  - This is intended behaviour; software clears edgecapture before unmasking.

## Timing
- Edge 1 is the first rising clk edge that samples a new in_port value. Let S = SYNC_STAGES and D = DEBOUNCE_CYCLES.
  - sync changes at edge S.
  - deb changes at edge S+D.
  - data visible on readdata (address 0) after edge S+D+1.
  - edgecapture bit set at edge S+D+1; visible on readdata (address 3) after edge S+D+2.
  - irq asserts at edge S+D+1 in level mode and at edge S+D+2 in edge mode.
- Read latency: 1 clock from address to readdata. Writes take effect at the strobing edge; readback follows on the next clock.
- Write-1-to-clear on edgecapture: irq (edge mode) deasserts one clock after the clearing write edge.
- No wait states; the block never stalls the bus.

## Test plan
Bench configuration for all scenarios: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, IRQ_MODE=1.
- Reset with in_port=8'h00 -> readdata=0 and irq=0. After release, reads of addresses 0, 1, 2 and 3 all return 32'h0.
- in_port 8'h00->8'h05 held -> address-0 readdata=32'h5 after edge 7. edgecapture=32'h5 after edge 8.
- Glitch: bit 3 high for 3 cycles, then low -> data and edgecapture bit 3 stay 0. A 4-cycle pulse sets edgecapture bit 3.
- Write irqmask=8'h01 with edgecapture=8'h05 -> irq=1 one clock later. Write 32'h1 to address 3 -> edgecapture=8'h04 and irq=0 one clock later.
- A rising edge on bit 0 lands on the same edge as a write-1-to-clear of bit 0 -> bit 0 remains 1.
- Reset asserted mid-debounce (counter=2) -> all outputs 0 immediately. After release with input held high, one capture appears at edge 7.

Source files
------------

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: input-only PIO slave for the Nios II system bus.
// It synchronises up to 32 external inputs and can optionally debounce each bit.
// Selected edges are captured in a sticky register that software clears
// with write-1-to-clear. A maskable interrupt is raised from that register
// (edge mode) or from the debounced data (level mode).
//
// Bus handshake: a write is accepted on every rising clk edge where
// chipselect=1 and write_n=0. Reads have no strobe: readdata is refreshed
// every clock from the current address. There is no ready/wait signal and
// the slave never stalls the bus.
module pio_in_edge_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ec_clear;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    // Upper writedata bits beyond WIDTH carry no register state.
    assign unused_wdata = ^writedata;

    // Synchroniser chain: stage 0 samples the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt_q [WIDTH];
            logic [WIDTH-1:0] deb_q;

            // Per-bit debounce: deb follows sync only after DEBOUNCE_CYCLES
            // consecutive cycles of disagreement; any agreement restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                    deb_q <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync[i] != deb_q[i]) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                deb_q[i] <= sync[i];
                                cnt_q[i] <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CW'(1);
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end
                end
            end

            assign deb = deb_q;
        end else begin : g_no_deb
            assign deb = sync;
        end
    endgenerate

    assign rise = deb & ~deb_d;
    assign fall = ~deb & deb_d;

    // Edge selection is fixed by EDGE_TYPE at elaboration.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
    end

    // Bits written as 1 to edgecapture are cleared; other bits are untouched.
    always_comb begin
        ec_clear = '0;
        if (wr_en && (address == 2'd3)) ec_clear = writedata[WIDTH-1:0];
    end

    // Delayed copy of deb for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb_d <= '0;
        else          deb_d <= deb;
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          irqmask <= '0;
        else if (wr_en && (address == 2'd2))   irqmask <= writedata[WIDTH-1:0];
    end

    // Sticky edge capture; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgecapture <= '0;
        else          edgecapture <= (edgecapture & ~ec_clear) | edge_hit;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = deb;
            2'd2:    rd_next[WIDTH-1:0] = irqmask;
            2'd3:    rd_next[WIDTH-1:0] = edgecapture;
            default: rd_next = '0;
        endcase
    end

    // Registered read data, one clock behind address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    // Registered interrupt from data (level) or from edgecapture (edge).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           irq <= 1'b0;
        else if (IRQ_MODE == 0) irq <= |(deb & irqmask);
        else                    irq <= |(edgecapture & irqmask);
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Testbench for pio_in_edge_irq (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=0 rising, IRQ_MODE=1 edge).
module tb_pio_in_edge_irq;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [W-1:0] m_pipe[$];    // synchroniser delay line, oldest first
    logic [W-1:0] m_shist[$];   // last D values seen at the synchroniser output
    logic [W-1:0] m_deb, m_deb_d, m_ec, m_mask;
    logic         m_irq;
    logic [31:0]  exp_q[$];     // expected readdata, one entry per edge

    pio_in_edge_irq #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .IRQ_MODE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pipe = {};
        for (int s = 0; s < S; s++) m_pipe.push_back('0);
        m_shist = {};
        m_deb = '0; m_deb_d = '0; m_ec = '0; m_mask = '0; m_irq = 1'b0;
        exp_q = {};
        exp_q.push_back(32'h0);
    endtask

    // One clock edge of the specified behaviour, using the inputs as sampled.
    task automatic model_edge();
        logic [W-1:0] sync_now, n_deb, rise, clr;
        logic [31:0]  n_rd;
        logic         n_irq;
        bit           all_differ;
        sync_now = m_pipe[0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(in_port);
        // deb adopts sync once the last D sync samples all disagreed with it.
        m_shist.push_back(sync_now);
        if (m_shist.size() > D) void'(m_shist.pop_front());
        n_deb = m_deb;
        if (m_shist.size() == D) begin
            for (int b = 0; b < W; b++) begin
                all_differ = 1'b1;
                foreach (m_shist[k]) if (m_shist[k][b] == m_deb[b]) all_differ = 1'b0;
                if (all_differ) n_deb[b] = sync_now[b];
            end
        end
        rise = m_deb & ~m_deb_d;
        clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        case (address)
            2'd0:    n_rd = {24'h0, m_deb};
            2'd2:    n_rd = {24'h0, m_mask};
            2'd3:    n_rd = {24'h0, m_ec};
            default: n_rd = 32'h0;
        endcase
        n_irq = |(m_ec & m_mask);
        m_ec  = (m_ec & ~clr) | rise;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_deb_d = m_deb;
        m_deb   = n_deb;
        m_irq   = n_irq;
        exp_q = {};
        exp_q.push_back(n_rd);
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic tick(input string tag);
        logic [31:0] e;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        #1;
        e = exp_q.pop_front();
        check({tag, " readdata"}, readdata, e);
        check({tag, " irq"}, {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick("write");
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    initial begin
        int hold;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = '0;
        model_reset();
        #2;
        check("reset readdata", readdata, 32'h0);
        check("reset irq", {31'h0, irq}, 32'h0);
        repeat (2) tick("in_reset");
        reset_n = 1'b1;
        repeat (3) tick("idle");
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick("read_map");
            check($sformatf("reg%0d after reset", a), readdata, 32'h0);
        end

        // Stable 0x05: data after edge 7, edgecapture after edge 8.
        address = 2'd0; in_port = 8'h05;
        repeat (6) tick("rise5");
        check("data e6", readdata, 32'h0);
        tick("rise5");
        check("data e7", readdata, 32'h5);
        address = 2'd3;
        tick("rise5");
        check("edgecapture e8", readdata, 32'h5);

        // Three-cycle glitch on bit 3 is filtered out.
        address = 2'd0; in_port = 8'h0d;
        repeat (3) tick("glitch3");
        in_port = 8'h05;
        repeat (8) tick("glitch3");
        check("glitch3 data", readdata, 32'h5);
        address = 2'd3;
        tick("glitch3");
        check("glitch3 edgecapture", readdata, 32'h5);

        // Four-cycle pulse on bit 3 passes and is captured.
        address = 2'd0; in_port = 8'h0d;
        repeat (4) tick("pulse4");
        in_port = 8'h05;
        repeat (3) tick("pulse4");
        check("pulse4 data e7", readdata, 32'h0d);
        repeat (6) tick("pulse4");
        address = 2'd3;
        tick("pulse4");
        check("pulse4 edgecapture", readdata, 32'h0d);

        // Mask and write-1-to-clear.
        bus_write(2'd3, 32'h08);
        tick("clr3");
        check("edgecapture after clr3", readdata, 32'h5);
        bus_write(2'd2, 32'h01);
        check("irq at mask edge", {31'h0, irq}, 32'h0);
        tick("mask");
        check("irq after mask", {31'h0, irq}, 32'h1);
        bus_write(2'd3, 32'h01);
        check("irq at clear edge", {31'h0, irq}, 32'h1);
        tick("clr0");
        check("irq after clear", {31'h0, irq}, 32'h0);
        check("edgecapture after clr0", readdata, 32'h4);

        // Rising edge and clear of bit 0 on the same edge: set wins.
        address = 2'd0; in_port = 8'h04;
        repeat (10) tick("fall0");
        check("data after fall0", readdata, 32'h4);
        in_port = 8'h05;
        repeat (6) tick("collide");
        bus_write(2'd3, 32'h01);
        tick("collide");
        check("edgecapture set wins", readdata, 32'h5);
        check("irq after collide", {31'h0, irq}, 32'h1);

        // Reset mid-debounce with the input held high.
        address = 2'd3; in_port = 8'h07;
        repeat (4) tick("mid_deb");
        reset_n = 1'b0;
        #1;
        check("async reset readdata", readdata, 32'h0);
        check("async reset irq", {31'h0, irq}, 32'h0);
        model_reset();
        repeat (2) tick("in_reset2");
        reset_n = 1'b1;
        repeat (7) tick("post_reset");
        check("post reset ec e7", readdata, 32'h0);
        tick("post_reset");
        check("post reset ec e8", readdata, 32'h7);
        bus_write(2'd3, 32'h07);
        tick("post_reset_clr");
        repeat (10) tick("post_reset_clr");
        check("single capture", readdata, 32'h0);

        // Randomised traffic against the model.
        hold = 0;
        repeat (600) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            address = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1: begin chipselect = 1'b1; write_n = 1'b0; writedata = $urandom; end
                2:    begin chipselect = 1'b1; write_n = 1'b1; writedata = $urandom; end
                3:    begin chipselect = 1'b0; write_n = 1'b0; writedata = $urandom; end
                default: begin chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; end
            endcase
            tick("random");
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
